// File: rtl/gpio_pkg.sv
// Shared constants for the gpio_port register interface: address width and register map.
package gpio_pkg;

    localparam int GPIO_ADDR_W = 3;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR   = 3'd0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT   = 3'd1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_PIN   = 3'd2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IEN   = 3'd3;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IEDGE = 3'd4;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IFLAG = 3'd5;

endpackage

// File: rtl/gpio_port_if.sv
// Core-side register bus of gpio_port: address, strobes, data in both directions and IRQ.
interface gpio_port_if
    import gpio_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [GPIO_ADDR_W-1:0] ADDR;
    logic                   WR_EN;
    logic                   RD_EN;
    logic [WIDTH-1:0]       DATA_IN;
    logic [WIDTH-1:0]       DATA_OUT;
    logic                   IRQ;

    modport master (
        output ADDR, WR_EN, RD_EN, DATA_IN,
        input  DATA_OUT, IRQ
    );

    modport slave (
        input  ADDR, WR_EN, RD_EN, DATA_IN,
        output DATA_OUT, IRQ
    );

endinterface

// File: rtl/gpio_sync.sv
// WIDTH-bit multi-flop synchroniser bringing asynchronous pad levels into the CLK domain.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    // Index 0 captures the pad; index STAGES-1 is the settled value. STAGES must be >= 2.
    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    // NOTE: every stage is reset so no stale pad level survives into PIN after a mid-run reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Bidirectional I/O port: direction/output latches, synchronised readback and
// per-pin edge-detect interrupt flags behind a small register-mapped bus.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    gpio_port_if.slave       bus,
    inout  wire  [WIDTH-1:0] IO
);

    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_ien;
    logic [WIDTH-1:0] r_iedge;
    logic [WIDTH-1:0] r_iflag;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_data_out;

    logic [WIDTH-1:0] w_pin;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_data;

    // Pads follow register flops only, so they go high-Z the moment reset clears r_dir.
    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign IO[g] = r_dir[g] ? r_out[g] : 1'bz;
    end

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK     (CLK),
        .RST     (RST),
        .i_async (IO),
        .o_sync  (w_pin)
    );

    // Selected edge between PREV and PIN, on input pins only.
    assign w_event = ~r_dir & ((~r_iedge & w_pin & ~r_prev) | (r_iedge & ~w_pin & r_prev));
    assign w_clr   = (bus.WR_EN && bus.ADDR == GPIO_IFLAG) ? bus.DATA_IN : '0;

    // NOTE: default first, then override, so no path leaves w_rd_data unassigned (no latch).
    always_comb begin
        w_rd_data = '0;
        case (bus.ADDR)
            GPIO_DIR:   w_rd_data = r_dir;
            GPIO_OUT:   w_rd_data = r_out;
            GPIO_PIN:   w_rd_data = w_pin;
            GPIO_IEN:   w_rd_data = r_ien;
            GPIO_IEDGE: w_rd_data = r_iedge;
            GPIO_IFLAG: w_rd_data = r_iflag;
            default:    w_rd_data = '0;
        endcase
    end

    // NOTE: non-blocking updates let a read in the write cycle see the pre-write value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dir      <= '0;
            r_out      <= '0;
            r_ien      <= '0;
            r_iedge    <= '0;
            r_iflag    <= '0;
            r_prev     <= '0;
            r_data_out <= '0;
        end else begin
            if (bus.WR_EN) begin
                case (bus.ADDR)
                    GPIO_DIR:   r_dir   <= bus.DATA_IN;
                    GPIO_OUT:   r_out   <= bus.DATA_IN;
                    GPIO_IEN:   r_ien   <= bus.DATA_IN;
                    GPIO_IEDGE: r_iedge <= bus.DATA_IN;
                    default:    ;
                endcase
            end
            // A new event outranks a W1C landing on the same edge.
            r_iflag <= (r_iflag & ~w_clr) | w_event;
            r_prev  <= w_pin;
            if (bus.RD_EN) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign bus.DATA_OUT = r_data_out;
    assign bus.IRQ      = |(r_iflag & r_ien);

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port: directed scenarios plus random traffic against a register-level model.
module tb_gpio_port;
    import gpio_pkg::*;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpio_port_if #(.WIDTH(WIDTH)) bus();

    logic [WIDTH-1:0] tb_drv;
    logic [WIDTH-1:0] tb_oe;
    wire  [WIDTH-1:0] io_pad;

    for (genvar g = 0; g < WIDTH; g++) begin : g_drv
        assign io_pad[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
    end

    gpio_port #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus),
        .IO  (io_pad)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: register contents, plus a queue of past pad samples standing in for the synchroniser.
    logic [WIDTH-1:0] m_dir, m_out, m_ien, m_iedge, m_iflag, m_prev, m_dout;
    logic [WIDTH-1:0] m_pads[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_irq();
        return |(m_iflag & m_ien);
    endfunction

    function automatic logic [WIDTH-1:0] m_read(input logic [2:0] a, input logic [WIDTH-1:0] pin);
        case (a)
            3'd0:    return m_dir;
            3'd1:    return m_out;
            3'd2:    return pin;
            3'd3:    return m_ien;
            3'd4:    return m_iedge;
            3'd5:    return m_iflag;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_dir = '0; m_out = '0; m_ien = '0; m_iedge = '0;
        m_iflag = '0; m_prev = '0; m_dout = '0;
        m_pads = {};
        repeat (SYNC) m_pads.push_back('0);
        tb_oe = ~m_dir;
    endtask

    // One clock edge of the model, using the values present just before the edge.
    task automatic model_step(input logic [2:0] a, input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] pad, pin, ev, clr;
        pad = (m_dir & m_out) | (~m_dir & tb_drv);
        pin = m_pads[0];
        ev  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!m_dir[i]) begin
                if (!m_iedge[i] && !m_prev[i] &&  pin[i]) ev[i] = 1'b1;
                if ( m_iedge[i] &&  m_prev[i] && !pin[i]) ev[i] = 1'b1;
            end
        end
        if (rd) m_dout = m_read(a, pin);
        clr = '0;
        if (wr) begin
            case (a)
                3'd0:    m_dir   = d;
                3'd1:    m_out   = d;
                3'd3:    m_ien   = d;
                3'd4:    m_iedge = d;
                3'd5:    clr     = d;
                default: ;
            endcase
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (ev[i])       m_iflag[i] = 1'b1;
            else if (clr[i]) m_iflag[i] = 1'b0;
        end
        m_prev = pin;
        void'(m_pads.pop_front());
        m_pads.push_back(pad);
    endtask

    // Drive one bus cycle, step the model at the edge, then compare IRQ, DATA_OUT and driven pads.
    task automatic cycle(input logic [2:0] a, input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        bus.ADDR    = a;
        bus.WR_EN   = wr;
        bus.RD_EN   = rd;
        bus.DATA_IN = d;
        @(posedge clk);
        model_step(a, wr, rd, d);
        #1 tb_oe = ~m_dir;
        #1;
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
        check("irq", {31'd0, bus.IRQ}, {31'd0, m_irq()});
        check("data_out", {24'd0, bus.DATA_OUT}, {24'd0, m_dout});
        check("io_drive", {24'd0, io_pad & m_dir}, {24'd0, m_out & m_dir});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [WIDTH-1:0] d);
        cycle(a, 1'b1, 1'b0, d);
    endtask

    task automatic rd_reg(input string tag, input logic [2:0] a, input logic [WIDTH-1:0] exp);
        cycle(a, 1'b0, 1'b1, '0);
        check(tag, {24'd0, bus.DATA_OUT}, {24'd0, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(3'd0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.ADDR = '0; bus.WR_EN = 1'b0; bus.RD_EN = 1'b0; bus.DATA_IN = '0;
        tb_drv = 8'h01;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: input held high across reset gives one rising event; then mid-cycle reset
        wr_reg(GPIO_IEN, 8'h01);
        idle(2);
        check("por_rise_irq", {31'd0, bus.IRQ}, 32'd1);
        wr_reg(GPIO_DIR, 8'hFF);
        wr_reg(GPIO_OUT, 8'hA5);
        check("t1_io_drive", {24'd0, io_pad}, 32'hA5);
        rd_reg("t1_rd_dir", GPIO_DIR, 8'hFF);
        #1 rst = 1'b1;
        #1;
        check("t1_rst_irq", {31'd0, bus.IRQ}, 32'd0);
        check("t1_rst_dout", {24'd0, bus.DATA_OUT}, 32'd0);
        tb_oe  = 8'hFF;
        tb_drv = 8'h5A;
        #1;
        check("t1_rst_hiz", {24'd0, io_pad}, 32'h5A);
        tb_drv = 8'h00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 6; a++) rd_reg("t1_reg_zero", 3'(a), 8'h00);

        // 2: output drive in the write cycle, and PIN readback of mixed pads
        wr_reg(GPIO_DIR, 8'h0F);
        tb_drv = 8'hA0;
        wr_reg(GPIO_OUT, 8'h3C);
        check("t2_io_lo", {28'd0, io_pad[3:0]}, 32'hC);
        check("t2_io_hi", {28'd0, io_pad[7:4]}, 32'hA);
        idle(2);
        rd_reg("t2_pin", GPIO_PIN, 8'hAC);

        // 3: rising edge on bit 7 flags exactly three edges after the pad change
        tb_drv = 8'h01;
        wr_reg(GPIO_DIR, 8'h00);
        wr_reg(GPIO_IEDGE, 8'h00);
        wr_reg(GPIO_IEN, 8'h80);
        idle(3);
        wr_reg(GPIO_IFLAG, 8'hFF);
        idle(1);
        tb_drv = 8'h80;
        idle(1);
        check("t3_irq_e1", {31'd0, bus.IRQ}, 32'd0);
        idle(1);
        check("t3_irq_e2", {31'd0, bus.IRQ}, 32'd0);
        idle(1);
        check("t3_irq_e3", {31'd0, bus.IRQ}, 32'd1);
        rd_reg("t3_iflag", GPIO_IFLAG, 8'h80);

        // 4: falling edge with IEN gating, then enable and W1C
        wr_reg(GPIO_IEDGE, 8'h01);
        wr_reg(GPIO_IEN, 8'h00);
        tb_drv = 8'h01;
        idle(3);
        wr_reg(GPIO_IFLAG, 8'hFF);
        tb_drv = 8'h00;
        idle(3);
        rd_reg("t4_iflag", GPIO_IFLAG, 8'h01);
        check("t4_irq_gated", {31'd0, bus.IRQ}, 32'd0);
        wr_reg(GPIO_IEN, 8'h01);
        check("t4_irq_en", {31'd0, bus.IRQ}, 32'd1);
        wr_reg(GPIO_IFLAG, 8'h01);
        check("t4_irq_clr", {31'd0, bus.IRQ}, 32'd0);

        // 5: W1C landing on the same edge as a new event keeps the flag
        wr_reg(GPIO_IEDGE, 8'h00);
        wr_reg(GPIO_IEN, 8'h80);
        tb_drv = 8'h80;
        idle(3);
        check("t5_first_irq", {31'd0, bus.IRQ}, 32'd1);
        tb_drv = 8'h00;
        idle(3);
        tb_drv = 8'h80;
        idle(2);
        wr_reg(GPIO_IFLAG, 8'h80);
        check("t5_collide_irq", {31'd0, bus.IRQ}, 32'd1);
        rd_reg("t5_iflag", GPIO_IFLAG, 8'h80);

        // 6: output pins never flag; addresses 6 and 7 are inert
        tb_drv = 8'h00;
        idle(3);
        wr_reg(GPIO_IFLAG, 8'hFF);
        wr_reg(GPIO_DIR, 8'h04);
        wr_reg(GPIO_OUT, 8'h00);
        idle(3);
        wr_reg(GPIO_OUT, 8'h04);
        idle(3);
        wr_reg(GPIO_OUT, 8'h00);
        idle(3);
        cycle(GPIO_IFLAG, 1'b0, 1'b1, '0);
        check("t6_iflag2", {31'd0, bus.DATA_OUT[2]}, 32'd0);
        rd_reg("t6_rd6", 3'd6, 8'h00);
        rd_reg("t6_rd7", 3'd7, 8'h00);
        wr_reg(3'd6, 8'hFF);
        wr_reg(3'd7, 8'hFF);
        rd_reg("t6_dir", GPIO_DIR, 8'h04);
        rd_reg("t6_out", GPIO_OUT, 8'h00);
        rd_reg("t6_ien", GPIO_IEN, 8'h80);
        rd_reg("t6_iedge", GPIO_IEDGE, 8'h00);
        rd_reg("t6_rd6b", 3'd6, 8'h00);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) tb_drv = 8'($urandom);
            cycle(3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised bidirectional I/O port for the RISCY core, replacing the fixed 8-bit port data/direction register pair. It provides per-pin direction, an output latch, a synchronised pin readback, and per-pin edge-detect interrupt flags behind a small register-mapped interface. It sits between the core's internal data bus and the chip-level `IO` pads, and drives a single `IRQ` line toward the core.

## Interface
- `WIDTH`, 8, number of I/O pins and the data width of the register interface.
- `SYNC_STAGES`, 2, number of input synchroniser flops per pin; must be ≥ 2.

Ports:
- `CLK`  in  1  single clock; all state changes on rising edge.
- `RST`  in  1  reset; asynchronous and active-high.
- `ADDR`  in  3  register select.
- `WR_EN`  in  1  write strobe for the register selected by `ADDR`.
- `RD_EN`  in  1  read strobe for the register selected by `ADDR`.
- `DATA_IN`  in  WIDTH  write data from the core bus.
- `DATA_OUT`  out  WIDTH  registered read data.
- `IO`  inout  WIDTH  pads; each bit is driven when its `DIR` bit is 1, otherwise high-Z.
- `IRQ`  out  1  interrupt request, equal to the OR of (`IFLAG` & `IEN`).

## Operation
- Register map:
  - 0 `DIR`, R/W; 1 = output.
  - 1 `OUT`, R/W; output latch.
  - 2 `PIN`, read-only; synchronised pad value for all bits, including read-back of driven pins.
  - 3 `IEN`, R/W; interrupt enable.
  - 4 `IEDGE`, R/W; 0 = rising edge, 1 = falling edge.
  - 5 `IFLAG`, read returns flags; write-1-to-clear.
  - 6–7: reads return 0; writes are ignored.
- `IO[i]` = `OUT[i]` when `DIR[i]` = 1, else Z. The pad follows register flops only, so it changes in the same cycle as the write edge.
- Synchroniser: `PIN` is the last stage of a `SYNC_STAGES` chain. A `PREV` flop holds the previous `PIN`.
- Edge event on bit i: `DIR[i]` = 0 and the selected edge is seen between `PREV[i]` and `PIN[i]`. Output pins never set flags.
- `IFLAG[i]` sets on an edge event regardless of `IEN[i]`. `IEN` gates only `IRQ`.
- Simultaneous events:
  - W1C on a bit in the same cycle as a new event on that bit: the set wins, so the flag stays 1.
  - `WR_EN` and `RD_EN` to the same address in one cycle: the read returns the pre-write value.
- Changing `IEDGE` or `DIR` can itself create an event on the next compare. This is intended; software clears `IFLAG` afterwards.
- Reset, asynchronous and effective mid-operation:
  - `DIR`, `OUT`, `IEN`, `IEDGE`, `IFLAG`, the synchroniser chain, `PREV`, and `DATA_OUT` all go to 0.
  - `IRQ` goes to 0 and all `IO` pins go high-Z immediately.
- `PREV` reloads from `PIN` every cycle. Reset leaves it 0, so an input held high across reset produces one rising event after release.

## Timing
- Write: takes effect at the rising edge where `WR_EN` = 1.
- Read: `DATA_OUT` is updated at the rising edge where `RD_EN` = 1 (1-cycle latency) and holds until the next read.
- Pad to `PIN`: `SYNC_STAGES` edges.
- Pad to `IFLAG`: `SYNC_STAGES` + 1 edges.
- `IFLAG` to `IRQ`: combinational from flops, so `IRQ` asserts in the same cycle `IFLAG` sets.
- `IRQ` deasserts the cycle after the W1C edge, provided no new event occurs on that edge.

## Structure
- Package `gpio_pkg`:
  - address constants `GPIO_DIR`, `GPIO_OUT`, `GPIO_PIN`, `GPIO_IEN`, `GPIO_IEDGE`, `GPIO_IFLAG`;
  - `ADDR` width constant = 3.
- One sub-module, `gpio_sync`: a `WIDTH`-bit, `SYNC_STAGES`-deep synchroniser with async active-high reset to 0.
- Register file, edge detect, and read mux live in `gpio_port`.

## Test plan
All scenarios use defaults (`WIDTH` = 8, `SYNC_STAGES` = 2).

1. Reset default state: assert `RST` mid-cycle with `DIR` = 0xFF and `OUT` = 0xA5. Required: `IO` goes to 0xZZ immediately; all registers, `DATA_OUT`, and `IRQ` go to 0.
2. Output drive and readback: write `DIR` = 0x0F, then `OUT` = 0x3C. Required: `IO[3:0]` = 4'b1100 in the write cycle and `IO[7:4]` stays Z. With the bench driving `IO[7:4]` = 4'b1010, reading `PIN` 2 or more cycles later returns 0xAC.
3. Rising-edge interrupt: `DIR` = 0, `IEN` = 0x80, `IEDGE` = 0. Bench drives `IO` from 0x01 to 0x80. Required: `IFLAG` = 0x80 and `IRQ` = 1 exactly 3 edges after the pad change; bit 0's falling edge sets no flag.
4. Falling edge, enable gating, and clear: `IEDGE` = 0x01, `IEN` = 0x00, `IO` goes from 0x01 to 0x00. Required: `IFLAG` = 0x01 and `IRQ` = 0. Then write `IEN` = 0x01: `IRQ` = 1. Then W1C `IFLAG` with 0x01: `IRQ` = 0 the next cycle.
5. Set-over-clear collision: time a W1C of bit 7 to land on the same edge as a new rising event on bit 7. Required: `IFLAG[7]` remains 1 and `IRQ` stays asserted.
6. Output pin masking and unused addresses: with `DIR[2]` = 1, toggle `OUT[2]`. Required: `IFLAG[2]` stays 0. Reads of `ADDR` 6 and 7 return 0x00, and writes to them change nothing.
